// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM result write-back path.
package gemm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ICB_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } icb_wr_t;

  // Word address of element idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return (base & ~32'h3) + (idx << 2);
  endfunction

endpackage

// File: rtl/gemm_sync_fifo.sv
// Synchronous FIFO with the head word held in an output register.
module gemm_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign push_ok = push & (count_q != CW'(DEPTH));
  assign pop_ok  = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Next head: incoming word when the FIFO would otherwise run dry, else the next stored entry.
    if (pop_ok) begin
      if (count_q == CW'(1)) head_d = wdata;
      else                   head_d = mem_q[rd_ptr_q + AW'(1)];
    end else if (count_q == '0) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign rdata = head_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/gemm_result_writer.sv
// Buffers GEMM result words and writes them over ICB to dst_base_addr + 4*index,
// tracking outstanding responses and reporting done/err for the NICE response.
module gemm_result_writer
  import gemm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTS   = 2,
  parameter int unsigned DIM_W      = 16
) (
  input  logic             nice_clk,
  input  logic             nice_rst,
  input  logic             start,
  input  logic [31:0]      dst_base_addr,
  input  logic [DIM_W-1:0] lhs_rows,
  input  logic [DIM_W-1:0] rhs_cols,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_data,
  output logic             nice_icb_cmd_valid,
  input  logic             nice_icb_cmd_ready,
  output logic [31:0]      nice_icb_cmd_addr,
  output logic             nice_icb_cmd_read,
  output logic [31:0]      nice_icb_cmd_wdata,
  output logic [1:0]       nice_icb_cmd_size,
  output logic             nice_mem_holdup,
  input  logic             nice_icb_rsp_valid,
  output logic             nice_icb_rsp_ready,
  input  logic             nice_icb_rsp_err,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned TW = 2 * DIM_W;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = 3;

  state_e        state_q, state_d;
  logic [TW-1:0] total_q, total_d;
  logic [TW-1:0] acc_q, acc_d;
  logic [TW-1:0] widx_q, widx_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   addr_q, addr_d;
  logic [OW-1:0] outs_q, outs_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          hold_q, hold_d;
  logic          rdy_q, rdy_d;
  logic          cvld_q, cvld_d;

  logic [CW-1:0] fifo_cnt, fifo_cnt_d;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic          push, pop, rsp_acc, rsp_orphan;
  logic [TW-1:0] job_total;
  icb_wr_t       cmd_pl;

  assign push       = res_valid & rdy_q & ~fifo_full;
  assign pop        = cvld_q & nice_icb_cmd_ready & ~fifo_empty;
  assign rsp_acc    = nice_icb_rsp_valid & (state_q != ST_IDLE) & (outs_q != '0);
  assign rsp_orphan = nice_icb_rsp_valid & (state_q != ST_IDLE) & (outs_q == '0);
  assign job_total  = TW'(lhs_rows) * TW'(rhs_cols);

  gemm_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (nice_clk),
    .rst   (nice_rst),
    .push  (push),
    .wdata (res_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    base_d     = base_q;
    acc_d      = acc_q + TW'(push);
    widx_d     = widx_q + TW'(pop);
    outs_d     = outs_q + OW'(pop) - OW'(rsp_acc);
    err_d      = err_q | rsp_orphan | (rsp_acc & nice_icb_rsp_err);
    fifo_cnt_d = fifo_cnt + CW'(push) - CW'(pop);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = dst_base_addr;
          total_d = job_total;
          acc_d   = '0;
          widx_d  = '0;
          err_d   = 1'b0;
          state_d = (job_total == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN:   if (acc_d == total_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((widx_d == total_q) && (outs_d == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    rdy_d  = (state_d == ST_RUN) && (fifo_cnt_d != CW'(FIFO_DEPTH)) && (acc_d < total_d);
    cvld_d = (fifo_cnt_d != '0) && (outs_d < OW'(MAX_OUTS));
    addr_d = word_addr(base_d, 32'(widx_d));
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    hold_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge nice_clk or posedge nice_rst) begin
    if (nice_rst) begin
      state_q <= ST_IDLE;
      total_q <= '0;
      acc_q   <= '0;
      widx_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      outs_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      widx_q  <= widx_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      outs_q  <= outs_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      rdy_q   <= rdy_d;
      cvld_q  <= cvld_d;
    end
  end

  assign cmd_pl             = '{addr: addr_q, data: fifo_head};
  assign res_ready          = rdy_q;
  assign nice_icb_cmd_valid = cvld_q;
  assign nice_icb_cmd_addr  = cmd_pl.addr;
  assign nice_icb_cmd_wdata = cmd_pl.data;
  assign nice_icb_cmd_read  = 1'b0;
  assign nice_icb_cmd_size  = ICB_SIZE_WORD;
  assign nice_icb_rsp_ready = 1'b1;
  assign nice_mem_holdup    = hold_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench for gemm_result_writer: result feeder, ICB responder and write monitor.
module tb_gemm_result_writer;

  logic        nice_clk = 1'b0;
  logic        nice_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_base_addr = '0;
  logic [15:0] lhs_rows = '0;
  logic [15:0] rhs_cols = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_data = '0;
  logic        nice_icb_cmd_valid;
  logic        nice_icb_cmd_ready = 1'b1;
  logic [31:0] nice_icb_cmd_addr;
  logic        nice_icb_cmd_read;
  logic [31:0] nice_icb_cmd_wdata;
  logic [1:0]  nice_icb_cmd_size;
  logic        nice_mem_holdup;
  logic        nice_icb_rsp_valid = 1'b0;
  logic        nice_icb_rsp_ready;
  logic        nice_icb_rsp_err = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  gemm_result_writer dut (
    .nice_clk           (nice_clk),
    .nice_rst           (nice_rst),
    .start              (start),
    .dst_base_addr      (dst_base_addr),
    .lhs_rows           (lhs_rows),
    .rhs_cols           (rhs_cols),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .nice_icb_cmd_valid (nice_icb_cmd_valid),
    .nice_icb_cmd_ready (nice_icb_cmd_ready),
    .nice_icb_cmd_addr  (nice_icb_cmd_addr),
    .nice_icb_cmd_read  (nice_icb_cmd_read),
    .nice_icb_cmd_wdata (nice_icb_cmd_wdata),
    .nice_icb_cmd_size  (nice_icb_cmd_size),
    .nice_mem_holdup    (nice_mem_holdup),
    .nice_icb_rsp_valid (nice_icb_rsp_valid),
    .nice_icb_rsp_ready (nice_icb_rsp_ready),
    .nice_icb_rsp_err   (nice_icb_rsp_err),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 nice_clk = ~nice_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result feeder: presents sequential words dbase+n until feed_total are accepted.
  int          feed_total = 0;
  int          sent = 0;
  logic        feed_en = 1'b0;
  logic [31:0] dbase = '0;
  logic        in_hs = 1'b0;

  always @(negedge nice_clk) in_hs = res_valid & res_ready;

  always @(posedge nice_clk) begin
    #1;
    if (in_hs) sent++;
    res_valid = feed_en && (sent < feed_total);
    res_data  = dbase + 32'(sent);
  end

  // Write monitor and outstanding-count model.
  int          cyc = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          pend_due[$];
  bit          pend_err[$];
  int          job_wr = 0;
  int          err_idx = -1;
  int          rsp_delay = 1;
  int          outs_m = 0;
  int          outs_max = 0;
  int          done_cnt = 0;
  int          rsp_cnt = 0;
  int          rsp_at_done = 0;
  int          viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_d = '0;

  always @(posedge nice_clk) cyc++;

  always @(negedge nice_clk) begin
    if (nice_rst) begin
      outs_m     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(nice_icb_cmd_valid && nice_icb_cmd_addr == prev_a &&
                          nice_icb_cmd_wdata == prev_d))
        viol++;
      prev_stall = nice_icb_cmd_valid && !nice_icb_cmd_ready;
      prev_a     = nice_icb_cmd_addr;
      prev_d     = nice_icb_cmd_wdata;
      if (nice_icb_rsp_valid) begin
        rsp_cnt++;
        if (outs_m > 0) outs_m--;
      end
      if (nice_icb_cmd_valid && nice_icb_cmd_ready) begin
        wa.push_back(nice_icb_cmd_addr);
        wd.push_back(nice_icb_cmd_wdata);
        pend_due.push_back(cyc + rsp_delay);
        pend_err.push_back(job_wr == err_idx);
        job_wr++;
        outs_m++;
      end
      if (outs_m > outs_max) outs_max = outs_m;
      if (done) begin
        done_cnt++;
        rsp_at_done = rsp_cnt;
      end
    end
  end

  // Responder: one write response per cycle once its delay has elapsed.
  always @(posedge nice_clk) begin
    #1;
    nice_icb_rsp_valid = 1'b0;
    nice_icb_rsp_err   = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      nice_icb_rsp_valid = 1'b1;
      nice_icb_rsp_err   = pend_err[0];
      void'(pend_due.pop_front());
      void'(pend_err.pop_front());
    end
  end

  task automatic start_job(input logic [31:0] base, input int m, input int n, input logic [31:0] db);
    @(posedge nice_clk); #2;
    dst_base_addr = base;
    lhs_rows      = 16'(m);
    rhs_cols      = 16'(n);
    start         = 1'b1;
    wa.delete();
    wd.delete();
    job_wr     = 0;
    done_cnt   = 0;
    rsp_cnt    = 0;
    outs_max   = 0;
    sent       = 0;
    dbase      = db;
    feed_total = m * n;
    feed_en    = 1'b1;
    @(posedge nice_clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge nice_clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] base,
                              input logic [31:0] db);
    check({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < wa.size()) begin
        check($sformatf("%s_addr%0d", tag, k), wa[k], base + 32'(4 * k));
        check($sformatf("%s_data%0d", tag, k), wd[k], db + 32'(k));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge nice_clk);
    #2;
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_cmd_valid", 32'(nice_icb_cmd_valid), 32'd0);
    check("rst_holdup", 32'(nice_mem_holdup), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("const_read", 32'(nice_icb_cmd_read), 32'd0);
    check("const_size", 32'(nice_icb_cmd_size), 32'd2);
    check("const_rsp_ready", 32'(nice_icb_rsp_ready), 32'd1);
    nice_rst = 1'b0;
    repeat (2) @(posedge nice_clk);

    // 1: 2x3 job, free-flowing handshakes, 1-cycle responses
    start_job(32'h0000_1000, 2, 3, 32'h1100_0000);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(100, "t1");
    repeat (3) @(negedge nice_clk);
    check_writes("t1", 6, 32'h0000_1000, 32'h1100_0000);
    check("t1_done_once", 32'(done_cnt), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_holdup_end", 32'(nice_mem_holdup), 32'd0);

    // 2: empty job completes without any command
    start_job(32'h0000_2000, 0, 5, 32'h2200_0000);
    check("t2_done_now", 32'(done), 32'd1);
    check("t2_holdup", 32'(nice_mem_holdup), 32'd1);
    check("t2_not_busy", 32'(busy), 32'd0);
    @(posedge nice_clk); #2;
    check("t2_done_cleared", 32'(done), 32'd0);
    check("t2_idle_holdup", 32'(nice_mem_holdup), 32'd0);
    repeat (3) @(negedge nice_clk);
    check("t2_nwrites", 32'(wa.size()), 32'd0);
    check("t2_done_once", 32'(done_cnt), 32'd1);

    // 3: command channel stalled; FIFO fills and backpressures the input
    nice_icb_cmd_ready = 1'b0;
    start_job(32'h0000_3000, 1, 8, 32'h3300_0000);
    repeat (20) @(negedge nice_clk);
    check("t3_accepted", 32'(sent), 32'd4);
    check("t3_res_ready_low", 32'(res_ready), 32'd0);
    check("t3_cmd_valid", 32'(nice_icb_cmd_valid), 32'd1);
    check("t3_hold_addr", nice_icb_cmd_addr, 32'h0000_3000);
    check("t3_hold_data", nice_icb_cmd_wdata, 32'h3300_0000);
    @(posedge nice_clk); #2;
    nice_icb_cmd_ready = 1'b1;
    wait_done(200, "t3");
    repeat (2) @(negedge nice_clk);
    check_writes("t3", 8, 32'h0000_3000, 32'h3300_0000);
    check("t3_stable", 32'(viol), 32'd0);
    check("t3_done_once", 32'(done_cnt), 32'd1);

    // 4: slow responses cap outstanding writes
    rsp_delay = 10;
    start_job(32'h0000_4000, 1, 4, 32'h4400_0000);
    wait_done(300, "t4");
    repeat (2) @(negedge nice_clk);
    check("t4_outs_max", 32'(outs_max), 32'd2);
    check("t4_rsp_before_done", 32'(rsp_at_done), 32'd4);
    check("t4_nwrites", 32'(wa.size()), 32'd4);
    check("t4_done_once", 32'(done_cnt), 32'd1);
    rsp_delay = 1;

    // 5: error response on the 2nd write does not abort the job
    err_idx = 1;
    start_job(32'h0000_5000, 1, 3, 32'h5500_0000);
    wait_done(100, "t5");
    repeat (2) @(negedge nice_clk);
    check("t5_err", 32'(err), 32'd1);
    check_writes("t5", 3, 32'h0000_5000, 32'h5500_0000);
    check("t5_done_once", 32'(done_cnt), 32'd1);
    err_idx = -1;

    // 6: address wrap; next start clears err
    start_job(32'hFFFF_FFF8, 1, 4, 32'h6600_0000);
    check("t6_err_cleared", 32'(err), 32'd0);
    wait_done(100, "t6");
    repeat (2) @(negedge nice_clk);
    check_writes("t6", 4, 32'hFFFF_FFF8, 32'h6600_0000);
    check("t6_err", 32'(err), 32'd0);

    // Mid-job reset with responses still in flight
    rsp_delay = 3;
    start_job(32'h0000_7000, 1, 8, 32'h7700_0000);
    repeat (6) @(negedge nice_clk);
    check("t7_busy_before", 32'(busy), 32'd1);
    #1;
    nice_rst = 1'b1;
    feed_en  = 1'b0;
    #2;
    check("t7_rst_res_ready", 32'(res_ready), 32'd0);
    check("t7_rst_cmd_valid", 32'(nice_icb_cmd_valid), 32'd0);
    check("t7_rst_holdup", 32'(nice_mem_holdup), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_done", 32'(done), 32'd0);
    check("t7_rst_err", 32'(err), 32'd0);
    @(posedge nice_clk); #3;
    nice_rst = 1'b0;
    repeat (8) @(negedge nice_clk);
    check("t7_post_err", 32'(err), 32'd0);
    check("t7_post_busy", 32'(busy), 32'd0);
    check("t7_post_cmd_valid", 32'(nice_icb_cmd_valid), 32'd0);
    check("t7_post_holdup", 32'(nice_mem_holdup), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
